gift_mem_ctrl: RTL and testbench

Access controller for the GIFT 136-bit single-port round-key memory (40 words, 8-bit address, registered read with one-cycle latency). It zero-fills the memory after reset, then shares its single port between a write requester (key-schedule unit) and a read requester (round datapath). It grants at most one memory operation per cycle, rejects out-of-range addresses, and returns read data with a fixed latency.

---
 rtl/gift_mem_ctrl.sv | 155 +++++++++++++++
 tb/tb_gift_mem_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/gift_mem_ctrl.sv
// Single-port access controller for the GIFT round-key memory: zero-fills after reset,
// then arbitrates write/read requesters. Define GIFT_MEM_CTRL_RR_EN for round-robin arbitration.
module gift_mem_ctrl #(
    parameter int unsigned DATA_W = 136,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 40
) (
    input  logic              inClk,
    input  logic              inRstN,
    input  logic              inWrReq,
    input  logic [ADDR_W-1:0] inWrAddr,
    input  logic [DATA_W-1:0] inWrData,
    output logic              outWrAck,
    input  logic              inRdReq,
    input  logic [ADDR_W-1:0] inRdAddr,
    output logic              outRdAck,
    output logic              outRdValid,
    output logic [DATA_W-1:0] outRdData,
    output logic              outErr,
    output logic              outReady,
    output logic              outMemWr,
    output logic              outMemRd,
    output logic [ADDR_W-1:0] outMemAddr,
    output logic [DATA_W-1:0] outMemData,
    input  logic [DATA_W-1:0] inMemData
);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] DEPTH_ADDR = ADDR_W'(DEPTH);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              rd_pend_q, rd_vld_q;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              run;
    logic              wr_grant, rd_grant;
    logic              wr_bad, rd_bad;

    // State register
    always_ff @(posedge inClk) begin
        if (!inRstN) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Strobes and acks are gated by reset so nothing reaches the memory while it is held.
    assign run = (state_q == ST_RUN) && inRstN;

`ifdef GIFT_MEM_CTRL_RR_EN
    logic rr_q, rr_d;   // 1: read is favoured on the next contended cycle

    always_comb begin
        wr_grant = run && inWrReq && !(inRdReq && rr_q);
        rr_d     = rr_q;
        if (run && inWrReq && inRdReq) begin
            rr_d = wr_grant;
        end
    end

    always_ff @(posedge inClk) begin
        if (!inRstN) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    always_comb begin
        wr_grant = run && inWrReq;
    end
`endif

    assign rd_grant = run && inRdReq && !wr_grant;
    assign wr_bad   = (inWrAddr >= DEPTH_ADDR);
    assign rd_bad   = (inRdAddr >= DEPTH_ADDR);

    // Output logic
    always_comb begin
        outWrAck   = 1'b0;
        outRdAck   = 1'b0;
        outErr     = 1'b0;
        outMemWr   = 1'b0;
        outMemRd   = 1'b0;
        outMemAddr = '0;
        outMemData = '0;
        outReady   = (state_q == ST_RUN);
        if (state_q == ST_INIT) begin
            if (inRstN) begin
                outMemWr   = 1'b1;
                outMemAddr = cnt_q;
            end
        end else begin
            outWrAck = wr_grant;
            outRdAck = rd_grant;
            outErr   = (wr_grant && wr_bad) || (rd_grant && rd_bad);
            if (wr_grant && !wr_bad) begin
                outMemWr   = 1'b1;
                outMemAddr = inWrAddr;
                outMemData = inWrData;
            end
            if (rd_grant && !rd_bad) begin
                outMemRd   = 1'b1;
                outMemAddr = inRdAddr;
            end
        end
    end

    // Read return: memory data is only looked at in the cycle after a read strobe.
    always_comb begin
        rd_data_d = rd_pend_q ? inMemData : rd_data_q;
    end

    always_ff @(posedge inClk) begin
        if (!inRstN) begin
            rd_pend_q <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_pend_q <= outMemRd;
            rd_vld_q  <= rd_pend_q;
            rd_data_q <= rd_data_d;
        end
    end

    assign outRdValid = rd_vld_q;
    assign outRdData  = rd_data_q;

endmodule

// File: tb/tb_gift_mem_ctrl.sv
// Directed, table-driven bench for gift_mem_ctrl with a behavioural single-port memory.
// Round-robin expectations apply when GIFT_MEM_CTRL_RR_EN is defined.
module tb_gift_mem_ctrl;

    localparam int DW    = 136;
    localparam int AW    = 8;
    localparam int DEPTH = 40;

    logic          inClk = 1'b0;
    logic          inRstN = 1'b0;
    logic          inWrReq = 1'b0;
    logic [AW-1:0] inWrAddr = '0;
    logic [DW-1:0] inWrData = '0;
    logic          inRdReq = 1'b0;
    logic [AW-1:0] inRdAddr = '0;
    logic          outWrAck, outRdAck, outRdValid, outErr, outReady;
    logic          outMemWr, outMemRd;
    logic [DW-1:0] outRdData, outMemData;
    logic [AW-1:0] outMemAddr;
    wire  [DW-1:0] inMemData;

    always #5 inClk = ~inClk;

    gift_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .inClk(inClk), .inRstN(inRstN),
        .inWrReq(inWrReq), .inWrAddr(inWrAddr), .inWrData(inWrData), .outWrAck(outWrAck),
        .inRdReq(inRdReq), .inRdAddr(inRdAddr), .outRdAck(outRdAck),
        .outRdValid(outRdValid), .outRdData(outRdData), .outErr(outErr), .outReady(outReady),
        .outMemWr(outMemWr), .outMemRd(outMemRd), .outMemAddr(outMemAddr),
        .outMemData(outMemData), .inMemData(inMemData)
    );

    // Single-port memory with registered read; bus floats except the cycle after a read.
    logic [DW-1:0] mem [0:DEPTH-1];
    logic [DW-1:0] mem_q = '0;
    logic          mem_rd_q = 1'b0;

    always @(posedge inClk) begin
        if (outMemWr && outMemAddr < AW'(DEPTH)) mem[outMemAddr] <= outMemData;
        mem_rd_q <= outMemRd;
        if (outMemRd && outMemAddr < AW'(DEPTH)) mem_q <= mem[outMemAddr];
    end
    assign inMemData = mem_rd_q ? mem_q : {DW{1'bz}};

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge inClk);
        #1;
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic          rd;
        logic [AW-1:0] raddr;
        logic          e_wack, e_rack, e_err, e_mwr, e_mrd;
        logic [AW-1:0] e_maddr;
        logic          e_vld;
        logic [DW-1:0] e_rdata;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic [AW-1:0] waddr, input logic [DW-1:0] wdata,
                                input logic rd, input logic [AW-1:0] raddr,
                                input logic wack, input logic rack, input logic err,
                                input logic mwr, input logic mrd, input logic [AW-1:0] maddr,
                                input logic vld, input logic [DW-1:0] rdata);
        vec_t v;
        v.wr = wr; v.waddr = waddr; v.wdata = wdata; v.rd = rd; v.raddr = raddr;
        v.e_wack = wack; v.e_rack = rack; v.e_err = err; v.e_mwr = mwr; v.e_mrd = mrd;
        v.e_maddr = maddr; v.e_vld = vld; v.e_rdata = rdata;
        return v;
    endfunction

    localparam logic [DW-1:0] DA = 136'hC30123456789ABCDEFFEDCBA98765432A5;
    localparam logic [DW-1:0] D1 = 136'h1100000000000000000000000000000011;
    localparam logic [DW-1:0] D2 = 136'h2200000000000000000000000000000022;
    localparam logic [DW-1:0] D3 = 136'h3300000000000000000000000000000033;
    localparam logic [DW-1:0] DX = {DW{1'b1}};
    localparam logic [DW-1:0] DC = 136'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A;

    vec_t vecs [14];
    logic exp_w;

    initial begin
        //                wr  wa       wdata  rd  ra       wak rak err mwr mrd maddr   vld rdata
        vecs[0]  = mk(1, 8'd5,   DA,   0, 8'd0,  1, 0, 0, 1, 0, 8'd5, 0, '0);
        vecs[1]  = mk(0, 8'd0,   '0,   1, 8'd5,  0, 1, 0, 0, 1, 8'd5, 0, '0);
        vecs[2]  = mk(1, 8'd1,   D1,   0, 8'd0,  1, 0, 0, 1, 0, 8'd1, 0, '0);
        vecs[3]  = mk(1, 8'd2,   D2,   0, 8'd0,  1, 0, 0, 1, 0, 8'd2, 1, DA);
        vecs[4]  = mk(1, 8'd3,   D3,   0, 8'd0,  1, 0, 0, 1, 0, 8'd3, 0, DA);
        vecs[5]  = mk(0, 8'd0,   '0,   1, 8'd1,  0, 1, 0, 0, 1, 8'd1, 0, DA);
        vecs[6]  = mk(0, 8'd0,   '0,   1, 8'd2,  0, 1, 0, 0, 1, 8'd2, 0, DA);
        vecs[7]  = mk(0, 8'd0,   '0,   1, 8'd3,  0, 1, 0, 0, 1, 8'd3, 1, D1);
        vecs[8]  = mk(0, 8'd0,   '0,   1, 8'd40, 0, 1, 1, 0, 0, 8'd0, 1, D2);
        vecs[9]  = mk(1, 8'd200, DX,   0, 8'd0,  1, 0, 1, 0, 0, 8'd0, 1, D3);
        vecs[10] = mk(0, 8'd0,   '0,   0, 8'd0,  0, 0, 0, 0, 0, 8'd0, 0, D3);
        vecs[11] = mk(0, 8'd0,   '0,   1, 8'd5,  0, 1, 0, 0, 1, 8'd5, 0, D3);
        vecs[12] = mk(0, 8'd0,   '0,   0, 8'd0,  0, 0, 0, 0, 0, 8'd0, 0, D3);
        vecs[13] = mk(0, 8'd0,   '0,   0, 8'd0,  0, 0, 0, 0, 0, 8'd0, 1, DA);

        // Reset state
        tick();
        tick();
        @(negedge inClk);
        check("rst ready", outReady, 0);
        check("rst rdvalid", outRdValid, 0);
        check("rst rddata", outRdData, 0);
        check("rst err", outErr, 0);
        check("rst memwr", outMemWr, 0);
        check("rst memrd", outMemRd, 0);
        check("rst acks", {outWrAck, outRdAck}, 0);
        tick();

        // Initialisation sweep, with a read of the last word held throughout
        inRstN = 1'b1;
        inRdReq = 1'b1;
        inRdAddr = 8'd39;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge inClk);
            check($sformatf("init%0d memwr", i), outMemWr, 1);
            check($sformatf("init%0d addr", i), outMemAddr, i);
            check($sformatf("init%0d data", i), outMemData, 0);
            check($sformatf("init%0d rdack", i), {outRdAck, outMemRd, outReady}, 0);
            tick();
        end
        @(negedge inClk);
        check("run ready", outReady, 1);
        check("run rdack", outRdAck, 1);
        check("run memrd", {outMemRd, outMemWr}, 2'b10);
        check("run addr", outMemAddr, 39);
        tick();
        inRdReq = 1'b0;
        @(negedge inClk);
        check("rd39 lat1 valid", outRdValid, 0);
        tick();
        @(negedge inClk);
        check("rd39 valid", outRdValid, 1);
        check("rd39 data", outRdData, 0);
        tick();

        // Table-driven single-requester traffic
        for (int i = 0; i < 14; i++) begin
            inWrReq = vecs[i].wr;   inWrAddr = vecs[i].waddr; inWrData = vecs[i].wdata;
            inRdReq = vecs[i].rd;   inRdAddr = vecs[i].raddr;
            @(negedge inClk);
            check($sformatf("row%0d wrack", i), outWrAck, vecs[i].e_wack);
            check($sformatf("row%0d rdack", i), outRdAck, vecs[i].e_rack);
            check($sformatf("row%0d err", i), outErr, vecs[i].e_err);
            check($sformatf("row%0d memwr", i), outMemWr, vecs[i].e_mwr);
            check($sformatf("row%0d memrd", i), outMemRd, vecs[i].e_mrd);
            check($sformatf("row%0d rdvalid", i), outRdValid, vecs[i].e_vld);
            check($sformatf("row%0d rddata", i), outRdData, vecs[i].e_rdata);
            if (vecs[i].e_mwr || vecs[i].e_mrd)
                check($sformatf("row%0d memaddr", i), outMemAddr, vecs[i].e_maddr);
            if (vecs[i].e_mwr)
                check($sformatf("row%0d memdata", i), outMemData, vecs[i].wdata);
            tick();
        end
        inWrReq = 1'b0;
        inRdReq = 1'b0;

        // Contention: both requesters held for six cycles
        inWrReq = 1'b1; inWrAddr = 8'd6; inWrData = DC;
        inRdReq = 1'b1; inRdAddr = 8'd5;
        for (int k = 0; k < 6; k++) begin
            @(negedge inClk);
`ifdef GIFT_MEM_CTRL_RR_EN
            exp_w = (k % 2 == 0);
`else
            exp_w = 1'b1;
`endif
            check($sformatf("arb%0d wrack", k), outWrAck, exp_w);
            check($sformatf("arb%0d rdack", k), outRdAck, !exp_w);
            check($sformatf("arb%0d strobes", k), {outMemWr, outMemRd}, {exp_w, !exp_w});
            tick();
        end
        inWrReq = 1'b0;
        inRdReq = 1'b0;
        tick();
        tick();
        @(negedge inClk);
        check("post-arb rddata", outRdData, DA);
        tick();

        // Reset one cycle after a read ack
        inRdReq = 1'b1;
        inRdAddr = 8'd6;
        @(negedge inClk);
        check("pre-rst rdack", outRdAck, 1);
        tick();
        inRdReq = 1'b0;
        inRstN = 1'b0;
        tick();
        inRstN = 1'b1;
        @(negedge inClk);
        check("midrst rdvalid", outRdValid, 0);
        check("midrst rddata", outRdData, 0);
        check("midrst ready", outReady, 0);
        check("midrst memwr", outMemWr, 1);
        check("midrst addr0", outMemAddr, 0);
        tick();
        @(negedge inClk);
        check("midrst rdvalid2", outRdValid, 0);
        check("midrst addr1", outMemAddr, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
